mdu: RTL and testbench

Iterative multiply/divide unit for the RV64IM M-extension, sitting in EX between `id_ex` and `ex_mem`, alongside the ALU. It accepts one M-type operation from `id_ex` and holds the front of the pipeline through `stall_o`. It computes the result by radix-2 shift-add or restoring division, then presents the result for one cycle so `ex_mem` captures it.

---
 rtl/mdu.sv | 167 ++++++++++++++++
 tb/tb_mdu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative RV64IM multiply/divide unit: radix-2 shift-add multiply and restoring
// division, one iteration per cycle, with divide-by-zero and overflow short-cut to DONE.
module mdu #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] srcA_i,
  input  logic [XLEN-1:0] srcB_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state;
  logic [6:0]        r_cnt;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_f3;
  logic              r_is_w;
  logic              r_neg;
  logic              r_rneg;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;

  // Operand decode for the op being offered this cycle.
  logic            w_is_w;
  logic [2:0]      w_f3;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_min_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;

  assign w_is_w     = op_i[3];
  // W forms of MULH/MULHSU/MULHU collapse to MULW.
  assign w_f3       = (op_i[3] && !op_i[2]) ? 3'b000 : op_i[2:0];
  assign w_is_div   = w_f3[2];
  assign w_a_signed = (w_f3 != 3'b011) && (w_f3 != 3'b101) && (w_f3 != 3'b111);
  assign w_b_signed = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                      (w_f3 == 3'b100) || (w_f3 == 3'b110);
  assign w_a_ext    = w_is_w ? {{32{w_a_signed & srcA_i[31]}}, srcA_i[31:0]} : srcA_i;
  assign w_b_ext    = w_is_w ? {{32{w_b_signed & srcB_i[31]}}, srcB_i[31:0]} : srcB_i;
  assign w_a_neg    = w_a_signed & w_a_ext[XLEN-1];
  assign w_b_neg    = w_b_signed & w_b_ext[XLEN-1];
  assign w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_min_neg  = w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign w_div_zero = w_is_div && (w_b_ext == '0);
  assign w_ovf      = w_is_div && !w_f3[0] && (w_a_ext == w_min_neg) && (w_b_ext == '1);
  assign w_spec_res = w_div_zero ? (w_f3[1] ? (w_is_w ? {{32{w_a_ext[31]}}, w_a_ext[31:0]} : w_a_ext) : '1)
                                 : (w_f3[1] ? '0 : w_a_ext);

  // One iteration of both datapaths; only the one matching r_f3 is consumed.
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quo_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_final;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvsr});
  // When w_ge holds the difference is below the divisor, so 64 bits suffice.
  assign w_sub      = w_shift[XLEN-1:0] - r_dvsr;
  assign w_rem_next = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
  assign w_prod     = r_neg ? -w_acc_next : w_acc_next;
  assign w_q        = r_neg ? -w_quo_next : w_quo_next;
  assign w_r        = r_rneg ? -w_rem_next : w_rem_next;

  always_comb begin
    w_raw = '0;
    case (r_f3)
      3'b000:                 w_raw = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_raw = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_raw = w_q;
      default:                w_raw = w_r;
    endcase
  end

  assign w_final = r_is_w ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_f3     <= w_f3;
            r_is_w   <= w_is_w;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_rneg   <= w_a_neg;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_b_mag};
            r_mplier <= w_a_mag;
            r_rem    <= '0;
            // W dividends sit in the top half so the MSB-first shift works for both widths.
            r_quo    <= w_is_w ? {w_a_mag[31:0], 32'h0} : w_a_mag;
            r_dvsr   <= w_b_mag;
            r_cnt    <= w_is_w ? 7'd32 : 7'd64;
            if (w_div_zero || w_ovf) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_rem    <= w_rem_next;
          r_quo    <= w_quo_next;
          r_cnt    <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stall_o  = ((r_state == IDLE) && start_i && !flush_i) || (r_state == CALC);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, results, special cases, flush and back-to-back issue.
module tb_mdu;

  logic        clock;
  logic        reset;
  logic        flush_i;
  logic        start_i;
  logic [3:0]  op_i;
  logic [63:0] srcA_i;
  logic [63:0] srcB_i;
  logic        stall_o;
  logic        done_o;
  logic [63:0] result_o;

  int checks;
  int errors;

  mdu #(.XLEN(64)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush_i  (flush_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .srcA_i   (srcA_i),
    .srcB_i   (srcB_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one op at the negedge (cycle 0), holds start_i until done_o, then drops it.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int cycles, output logic [63:0] res, output bit stall_ok,
                        output bit done_seen, output logic stall_at_done, output logic after_busy);
    @(negedge clock);
    start_i = 1'b1;
    op_i    = op;
    srcA_i  = a;
    srcB_i  = b;
    #1;
    stall_ok  = stall_o;
    cycles    = 0;
    done_seen = 1'b0;
    while (cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
      if (done_o) begin
        done_seen = 1'b1;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
    end
    res           = result_o;
    stall_at_done = stall_o;
    @(posedge clock);
    #1;
    start_i    = 1'b0;
    #1;
    after_busy = stall_o | done_o;
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int exp_cycles, input logic [63:0] exp_res);
    int          cycles;
    logic [63:0] res;
    bit          stall_ok;
    bit          done_seen;
    logic        stall_at_done;
    logic        after_busy;
    run_op(op, a, b, cycles, res, stall_ok, done_seen, stall_at_done, after_busy);
    checks++;
    if (!done_seen || cycles != exp_cycles) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (done=%0b), expected %0d", name, cycles, done_seen, exp_cycles);
    end
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h, expected %h", name, res, exp_res);
    end
    checks++;
    if (stall_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s stall: stall_o dropped before done, expected high in cycles 0..%0d", name, exp_cycles - 1);
    end
    checks++;
    if (stall_at_done !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_in_done: got %b, expected 0", name, stall_at_done);
    end
    checks++;
    if (after_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s reaccept: stall/done after DONE got %b, expected 0", name, after_busy);
    end
    $display("op %-8s A=%h B=%h -> %h in %0d cycles", name, a, b, res, cycles);
  endtask

  task automatic test_reset;
    bit idle_ok;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b done=%b result=%h, expected 0 0 0", stall_o, done_o, result_o);
    end
    reset = 1'b0;
    idle_ok = 1'b1;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (stall_o !== 1'b0 || done_o !== 1'b0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL idle_quiet: stall_o/done_o went high with start_i=0, expected 0");
    end
    checks++;
    if (result_o !== 64'h0) begin
      errors++;
      $display("FAIL idle_result: got %h, expected 0", result_o);
    end
    $display("reset/idle: stall=%b done=%b result=%h", stall_o, done_o, result_o);
  endtask

  task automatic test_mul;
    check_op("MUL",    4'b0000, -64'sd3, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFEB);
    check_op("MULHU",  4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    check_op("MULHSU", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    check_op("MULH",   4'b0001, 64'h4000_0000_0000_0000, 64'd8, 65, 64'h0000_0000_0000_0002);
    check_op("MULW",   4'b1000, 64'h1234_5678_7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE);
  endtask

  task automatic test_div;
    check_op("DIV",   4'b0100, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    check_op("REM",   4'b0110, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    check_op("DIVU",  4'b0101, 64'd1000, 64'd33, 65, 64'd30);
    check_op("REMU",  4'b0111, 64'd1000, 64'd33, 65, 64'd10);
    check_op("DIVW",  4'b1100, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
  endtask

  task automatic test_special;
    check_op("DIVWovf", 4'b1100, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000);
    check_op("REMUW0",  4'b1111, 64'd5, 64'd0, 1, 64'd5);
    check_op("DIVU0",   4'b0101, 64'd123, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    check_op("REMovf",  4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
  endtask

  task automatic test_flush;
    bit          no_done;
    int          cycles;
    logic [63:0] res;
    bit          stall_ok;
    bit          done_seen;
    logic        stall_at_done;
    logic        after_busy;
    @(negedge clock);
    start_i = 1'b1;
    op_i    = 4'b0101;
    srcA_i  = 64'd5000;
    srcB_i  = 64'd3;
    no_done = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      #1;
      if (done_o) no_done = 1'b0;
    end
    flush_i = 1'b1;
    @(posedge clock);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: cycle 21 stall_o got %b, expected 0", stall_o);
    end
    if (done_o) no_done = 1'b0;
    checks++;
    if (!no_done) begin
      errors++;
      $display("FAIL flush_done: done_o seen for flushed DIVU, expected none");
    end
    $display("flush at cycle 20: stall=%b done=%b", stall_o, done_o);
    @(posedge clock);
    run_op(4'b0101, 64'd100, 64'd7, cycles, res, stall_ok, done_seen, stall_at_done, after_busy);
    checks++;
    if (!done_seen || 22 + cycles != 87) begin
      errors++;
      $display("FAIL flush_restart_latency: done in cycle %0d, expected 87", 22 + cycles);
    end
    checks++;
    if (res !== 64'd14) begin
      errors++;
      $display("FAIL flush_restart_result: got %h, expected %h", res, 64'd14);
    end
    $display("op DIVU     A=%h B=%h -> %h done in cycle %0d", 64'd100, 64'd7, res, 22 + cycles);
  endtask

  task automatic test_flush_start;
    bit quiet;
    @(negedge clock);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 4'b0101;
    srcA_i  = 64'd9;
    srcB_i  = 64'd0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: got %b, expected 0", stall_o);
    end
    @(posedge clock);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done_o !== 1'b0 || stall_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL flush_start_accept: op accepted despite flush_i");
    end
    checks++;
    if (result_o !== 64'd14) begin
      errors++;
      $display("FAIL flush_start_result: got %h, expected %h", result_o, 64'd14);
    end
    $display("flush+start in IDLE: done=%b result=%h", done_o, result_o);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    flush_i = 1'b0;
    start_i = 1'b0;
    op_i    = 4'b0000;
    srcA_i  = 64'h0;
    srcB_i  = 64'h0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_flush_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
